mtime_counter: RTL and testbench

MTIME_COUNTER -- requirements
Module: mtime_counter

---
 rtl/mtime_counter_if.sv | 29 ++
 rtl/mtime_counter.sv | 73 +++++++
 tb/tb_mtime_counter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mtime_counter_if.sv
`default_nettype none
// ============================================================================
// mtime_counter_if : control/status bundle for the prescaled mtime counter
// Rev 1.0
// ============================================================================
interface mtime_counter_if;
  logic [15:0] div;
  logic        enable;
  logic        wr_lo;
  logic        wr_hi;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        snap;
  logic [63:0] timer_counter;
  logic [31:0] snap_hi;
  logic        tick;
  logic        wrap;

  modport master (
    output div, enable, wr_lo, wr_hi, wmask, wdata, snap,
    input  timer_counter, snap_hi, tick, wrap
  );

  modport slave (
    input  div, enable, wr_lo, wr_hi, wmask, wdata, snap,
    output timer_counter, snap_hi, tick, wrap
  );
endinterface
`default_nettype wire

// File: rtl/mtime_counter.sv
`default_nettype none
// ============================================================================
// mtime_counter : prescaled 64-bit machine timer with byte-masked writes and
//                 an upper-word snapshot for coherent split reads. Rev 1.0
// ============================================================================
module mtime_counter (
  input  wire logic      clk,
  input  wire logic      resetn,
  mtime_counter_if.slave bus
);
  logic [15:0] psc;
  logic [15:0] psc_next;
  logic [63:0] mtime;
  logic [63:0] mtime_next;
  logic [31:0] snap_hi;
  logic        tick;
  logic        tick_next;
  logic        wrap;
  logic        wrap_next;
  logic        wr_any;

  assign wr_any = bus.wr_lo | bus.wr_hi;

  // Writes win over counting; unselected bytes keep the pre-increment value.
  always_comb begin
    mtime_next = mtime;
    psc_next   = psc;
    tick_next  = 1'b0;
    wrap_next  = 1'b0;
    if (wr_any) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.wmask[n]) begin
          if (bus.wr_lo) mtime_next[8*n +: 8]      = bus.wdata[8*n +: 8];
          if (bus.wr_hi) mtime_next[32 + 8*n +: 8] = bus.wdata[8*n +: 8];
        end
      end
      psc_next = 16'd0;
    end else if (bus.enable) begin
      // >= lets a shrinking div end the current period on the next edge.
      if (psc >= bus.div) begin
        psc_next   = 16'd0;
        mtime_next = mtime + 64'd1;
        tick_next  = 1'b1;
        wrap_next  = &mtime;
      end else begin
        psc_next = psc + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      psc     <= 16'd0;
      mtime   <= 64'd0;
      snap_hi <= 32'd0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      psc   <= psc_next;
      mtime <= mtime_next;
      tick  <= tick_next;
      wrap  <= wrap_next;
      if (bus.snap) snap_hi <= mtime_next[63:32];
    end
  end

  assign bus.timer_counter = mtime;
  assign bus.snap_hi       = snap_hi;
  assign bus.tick          = tick;
  assign bus.wrap          = wrap;

endmodule
`default_nettype wire

// File: tb/tb_mtime_counter.sv
`default_nettype none
// ============================================================================
// tb_mtime_counter : table vectors, directed corner sequences and randomized
//                    stimulus against a behavioural mtime model. Rev 1.0
// ============================================================================
module tb_mtime_counter;
  logic clk    = 1'b0;
  logic resetn = 1'b0;

  mtime_counter_if bus ();

  mtime_counter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [63:0] m_mtime;
  int          m_psc;
  logic [31:0] m_snap;
  logic        m_tick;
  logic        m_wrap;

  typedef struct {
    logic [15:0] div;
    logic        en;
    logic        wl;
    logic        wh;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        snap;
    logic [63:0] e_tc;
    logic [31:0] e_snap;
    logic        e_tick;
    logic        e_wrap;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = 64'd0;
    m_psc   = 0;
    m_snap  = 32'd0;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
  endtask

  task automatic model_edge();
    logic [64:0] sum;
    if (!resetn) begin
      model_reset();
      return;
    end
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (bus.wr_lo || bus.wr_hi) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.wmask[n]) begin
          if (bus.wr_lo) m_mtime[8*n +: 8]      = bus.wdata[8*n +: 8];
          if (bus.wr_hi) m_mtime[32 + 8*n +: 8] = bus.wdata[8*n +: 8];
        end
      end
      m_psc = 0;
    end else if (bus.enable) begin
      if (m_psc >= int'(bus.div)) begin
        sum     = {1'b0, m_mtime} + 65'd1;
        m_mtime = sum[63:0];
        m_wrap  = sum[64];
        m_tick  = 1'b1;
        m_psc   = 0;
      end else begin
        m_psc = m_psc + 1;
      end
    end
    if (bus.snap) m_snap = m_mtime[63:32];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("timer_counter", bus.timer_counter, m_mtime);
    chk("snap_hi", {32'd0, bus.snap_hi}, {32'd0, m_snap});
    chk("tick", {63'd0, bus.tick}, {63'd0, m_tick});
    chk("wrap", {63'd0, bus.wrap}, {63'd0, m_wrap});
  endtask

  task automatic drive(input logic [15:0] d, input logic en, input logic wl, input logic wh,
                       input logic [3:0] mask, input logic [31:0] data, input logic sn);
    bus.div    = d;
    bus.enable = en;
    bus.wr_lo  = wl;
    bus.wr_hi  = wh;
    bus.wmask  = mask;
    bus.wdata  = data;
    bus.snap   = sn;
  endtask

  task automatic write64(input logic [63:0] v);
    drive(16'd0, 1'b0, 1'b0, 1'b1, 4'hF, v[63:32], 1'b0);
    step();
    drive(16'd0, 1'b0, 1'b1, 1'b0, 4'hF, v[31:0], 1'b0);
    step();
    drive(16'd0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          r;

    // div=3 from reset: ticks on edges 4, 8, 12
    for (int i = 0; i < 12; i++)
      tbl[i] = '{16'd3, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0,
                 64'((i + 1) / 4), 32'd0, ((i + 1) % 4 == 0), 1'b0};
    tbl[12] = '{16'd0, 1'b0, 1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0,
                64'hFFFF_FFFF_0000_0003, 32'd0, 1'b0, 1'b0};
    tbl[13] = '{16'd0, 1'b0, 1'b1, 1'b0, 4'hF, 32'hFFFF_FFFE, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 32'd0, 1'b0, 1'b0};
    tbl[14] = '{16'd0, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[15] = '{16'd0, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0,
                64'd0, 32'hFFFF_FFFF, 1'b1, 1'b1};
    tbl[16] = '{16'd0, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b1,
                64'd1, 32'd0, 1'b1, 1'b0};
    tbl[17] = '{16'd0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0,
                64'd1, 32'd0, 1'b0, 1'b0};
    tbl[18] = '{16'd0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h1234_5678, 1'b0,
                64'd1, 32'd0, 1'b0, 1'b0};
    tbl[19] = '{16'd0, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0,
                64'd2, 32'd0, 1'b1, 1'b0};

    // Reset held: inputs must be ignored
    model_reset();
    drive(16'd0, 1'b1, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1);
    step();
    step();
    chk("reset_tc", bus.timer_counter, 64'd0);
    chk("reset_snap", {32'd0, bus.snap_hi}, 64'd0);

    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].div, tbl[i].en, tbl[i].wl, tbl[i].wh, tbl[i].mask, tbl[i].data, tbl[i].snap);
      step();
      chk($sformatf("tbl%0d_tc", i), bus.timer_counter, tbl[i].e_tc);
      chk($sformatf("tbl%0d_snap", i), {32'd0, bus.snap_hi}, {32'd0, tbl[i].e_snap});
      chk($sformatf("tbl%0d_tick", i), {63'd0, bus.tick}, {63'd0, tbl[i].e_tick});
      chk($sformatf("tbl%0d_wrap", i), {63'd0, bus.wrap}, {63'd0, tbl[i].e_wrap});
    end

    // Partial-mask write on a terminal-count edge
    write64(64'h0000_0001_0000_0010);
    drive(16'd3, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0);
    repeat (3) step();
    drive(16'd3, 1'b1, 1'b1, 1'b0, 4'b0011, 32'hAAAA_5555, 1'b0);
    step();
    chk("mask_wr_tc", bus.timer_counter, 64'h0000_0001_0000_5555);
    chk("mask_wr_tick", {63'd0, bus.tick}, 64'd0);
    drive(16'd3, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0);
    repeat (3) step();
    chk("mask_wr_psc_hold", bus.timer_counter, 64'h0000_0001_0000_5555);
    step();
    chk("mask_wr_psc_inc", bus.timer_counter, 64'h0000_0001_0000_5556);

    // div shrink below current psc
    write64(64'd0);
    drive(16'd100, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0);
    repeat (50) step();
    chk("div_shrink_pre", bus.timer_counter, 64'd0);
    bus.div = 16'd10;
    step();
    chk("div_shrink_first", bus.timer_counter, 64'd1);
    chk("div_shrink_tick", {63'd0, bus.tick}, 64'd1);
    repeat (10) step();
    chk("div_shrink_hold", bus.timer_counter, 64'd1);
    step();
    chk("div_shrink_second", bus.timer_counter, 64'd2);

    // Snapshot on the carry edge
    write64(64'h0000_0002_FFFF_FFFF);
    drive(16'd0, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b1);
    step();
    chk("snap_carry_hi", {32'd0, bus.snap_hi}, 64'd3);
    chk("snap_carry_tc", bus.timer_counter, 64'h0000_0003_0000_0000);
    bus.snap = 1'b0;

    // Asynchronous reset mid-period
    write64(64'h0000_0000_0000_1234);
    drive(16'd7, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0);
    repeat (3) step();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_tc", bus.timer_counter, 64'd0);
    chk("async_rst_snap", {32'd0, bus.snap_hi}, 64'd0);
    chk("async_rst_tick", {63'd0, bus.tick}, 64'd0);
    drive(16'd7, 1'b1, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1);
    step();
    chk("rst_ignore_wr", bus.timer_counter, 64'd0);
    drive(16'd7, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 1'b0);
    #2;
    resetn = 1'b1;
    repeat (7) step();
    chk("post_rst_hold", bus.timer_counter, 64'd0);
    step();
    chk("post_rst_first", bus.timer_counter, 64'd1);
    chk("post_rst_tick", {63'd0, bus.tick}, 64'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      r  = int'($urandom_range(0, 99));
      rd = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      drive(16'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0),
            (r < 4) || (r >= 7 && r < 9), (r >= 4 && r < 9),
            4'($urandom_range(0, 15)), rd, ($urandom_range(0, 3) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
